// File: rtl/serial_add_arbiter_if.sv
// Request/response bundle for serial_add_arbiter.
// The master side is the client population, the slave side is the arbiter.
interface serial_add_arbiter_if #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     abort;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_sum;
  logic                     rsp_cout;
  logic                     busy;

  modport master (
    output req_valid, req_a, req_b, abort, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, abort, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/serial_add_arbiter.sv
// Round-robin shared bit-serial adder.
// One requester is granted at a time; its operands are added LSB-first over
// WIDTH cycles and the result is presented on a valid/ready response port.
module serial_add_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_add_arbiter_if.slave  bus
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CW-1:0]      count_q, count_d;

  logic [NUM_REQ-1:0] grant_vec;
  logic [IDW-1:0]     grant_id;
  logic [IDW-1:0]     next_ptr;
  logic               sum_bit;
  int unsigned        arb_idx;

  // Round-robin pick: scan farthest offset first so the nearest valid
  // requester to rr_ptr is the last (winning) write.
  always_comb begin
    grant_vec = '0;
    grant_id  = '0;
    arb_idx   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      arb_idx = 32'(rr_ptr_q) + (NUM_REQ - 1 - k);
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      if (bus.req_valid[arb_idx]) begin
        grant_vec          = '0;
        grant_vec[arb_idx] = 1'b1;
        grant_id           = IDW'(arb_idx);
      end
    end
  end

  // Pointer just past the current owner, wrapping at NUM_REQ.
  assign next_ptr = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  // Next-state, datapath shift and round-robin pointer update.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    count_d  = count_q;
    sum_bit  = a_q[0] ^ b_q[0] ^ carry_q;
    case (state_q)
      S_IDLE: begin
        if (|grant_vec) begin
          a_d     = bus.req_a[grant_id*WIDTH +: WIDTH];
          b_d     = bus.req_b[grant_id*WIDTH +: WIDTH];
          id_d    = grant_id;
          carry_d = 1'b0;
          count_d = CW'(WIDTH);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.abort) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
        end else begin
          carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          sum_d   = {sum_bit, sum_q[WIDTH-1:1]};
          count_d = count_q - 1'b1;
          if (count_q == CW'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.rsp_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
    end
  end

  // req_ready is gated by reset so no grant is offered while reset is held.
  assign bus.req_ready = (state_q == S_IDLE && reset) ? grant_vec : '0;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = carry_q;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DONE);
endmodule
